meta_update_unit: RTL and testbench
===================================

META_UPDATE_UNIT -- requirements
Module: meta_update_unit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state changes on the rising edge of CLK.
REQ-002 CLK  in  1  system clock.
REQ-003 RESET  in  1  synchronous active-high reset.
REQ-004 Pred_valid  in  1  a new branch prediction issued this cycle.
REQ-005 Pred_addr  in  32  instruction address of the predicted branch.
REQ-006 Pred_global  in  1  global predictor direction (1 = taken).
REQ-007 Pred_local  in  1  local predictor direction (1 = taken).
REQ-008 Resolve_valid  in  1  the oldest in-flight branch resolved this cycle.
REQ-009 Resolve_addr  in  32  address of the resolving branch.
REQ-010 Resolve_taken  in  1  actual branch outcome.
REQ-011 Flush  in  1  discard all in-flight predictions.
REQ-012 Meta_update_valid  out  1  one-cycle chooser-update strobe.
REQ-013 Meta_update_addr  out  32  address whose chooser entry is updated; bits [11:2] index the 1024-entry table.
REQ-014 Meta_prefer_global  out  1  1 = move chooser counter toward global, 0 = toward local.
REQ-015 Full / Empty  out  1 each  queue status.
REQ-016 Count  out  3  in-flight entries, 0..4.
REQ-017 Order_error / Overflow  out  1 each  sticky error flags.
REQ-018 Global_correct_cnt / Local_correct_cnt  out  16 each  statistics (see Configuration).

Function
REQ-019 SHALL hold a 4-entry in-order queue; each entry stores {Pred_addr, Pred_global, Pred_local}.
REQ-020 Push: Pred_valid with not Full, or Full with simultaneous pop, writes at tail; Count increments unless a pop occurs in the same cycle.
REQ-021 Push while Full with no pop SHALL drop the prediction and set Overflow.
REQ-022 Pop: Resolve_valid with not Empty removes the head entry.
REQ-023 Resolve_valid while Empty SHALL be ignored; no strobe, no flag.
REQ-024 Popped head with Resolve_addr equal to the stored address, and Pred_global != Pred_local: the cycle after the pop, Meta_update_valid=1, Meta_update_addr=stored address, Meta_prefer_global=(Pred_global==Resolve_taken).
REQ-025 Popped head with Pred_global == Pred_local SHALL produce no strobe; the chooser is untouched when predictors agree.
REQ-026 Popped head with address mismatch SHALL set Order_error, pop the entry anyway, and produce no strobe.
REQ-027 Update latency SHALL be exactly one cycle from the Resolve_valid edge; back-to-back resolves give back-to-back strobes.
REQ-028 Flush SHALL empty the queue (Count=0, pointers reset) in one cycle and override any push or pop in that cycle; a strobe already registered from the previous cycle still completes.
REQ-029 Head/tail pointers SHALL wrap modulo 4; Full = (Count==4), Empty = (Count==0).
REQ-030 Meta_update_addr and Meta_prefer_global SHALL hold their last value when Meta_update_valid=0.

Reset
REQ-031 RESET SHALL clear Count, pointers, Meta_update_valid, Meta_update_addr, Meta_prefer_global, Order_error, Overflow and both statistic counters to 0; Empty=1, Full=0.
REQ-032 RESET mid-operation SHALL discard all entries and suppress any pending strobe; reset overrides Flush, push and pop.

Configuration
REQ-033 Macro META_UPDATE_STATS_EN: when defined, each strobe increments Global_correct_cnt if Meta_prefer_global=1, else Local_correct_cnt; counters saturate at 16'hFFFF.
REQ-034 Without META_UPDATE_STATS_EN, both statistic outputs SHALL be tied to 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-035 Push addr 0x00400010 (global=1, local=0), resolve same addr taken=1 -> next cycle strobe=1, addr=0x00400010, prefer_global=1; Count back to 0.
REQ-036 Push addr 0x00400020 (global=1, local=1), resolve taken=0 -> no strobe; Count 1->0.
REQ-037 Push 5 predictions without resolve -> Count=4, Full=1, Overflow=1, 5th dropped; 4 resolves in order -> strobes for the first 4 addresses only.
REQ-038 Push 0x00400030, resolve with 0x00400034 -> Order_error=1, Empty=1, no strobe.
REQ-039 Count=3, assert Flush with Pred_valid and Resolve_valid in same cycle -> Count=0, Empty=1, no new strobe.
REQ-040 With META_UPDATE_STATS_EN: 3 global-correct and 2 local-correct disagreeing resolves -> Global_correct_cnt=3, Local_correct_cnt=2; without macro both read 0.

Source files
------------

// File: rtl/meta_update_unit_if.sv
// Bus bundle for meta_update_unit: prediction push, resolve pop, flush,
// chooser-update strobe, queue status and statistics.
interface meta_update_unit_if;
    logic        pred_valid;
    logic [31:0] pred_addr;
    logic        pred_global;
    logic        pred_local;
    logic        resolve_valid;
    logic [31:0] resolve_addr;
    logic        resolve_taken;
    logic        flush;

    logic        meta_update_valid;
    logic [31:0] meta_update_addr;
    logic        meta_prefer_global;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        order_error;
    logic        overflow;
    logic [15:0] global_correct_cnt;
    logic [15:0] local_correct_cnt;

    modport master (
        output pred_valid, pred_addr, pred_global, pred_local,
        output resolve_valid, resolve_addr, resolve_taken, flush,
        input  meta_update_valid, meta_update_addr, meta_prefer_global,
        input  full, empty, count, order_error, overflow,
        input  global_correct_cnt, local_correct_cnt
    );

    modport slave (
        input  pred_valid, pred_addr, pred_global, pred_local,
        input  resolve_valid, resolve_addr, resolve_taken, flush,
        output meta_update_valid, meta_update_addr, meta_prefer_global,
        output full, empty, count, order_error, overflow,
        output global_correct_cnt, local_correct_cnt
    );
endinterface

// File: rtl/meta_update_unit.sv
// Tournament-chooser update unit: 4-deep in-order queue of predictions, emits a
// chooser strobe when the two predictors disagreed. Optional stats: META_UPDATE_STATS_EN.
module meta_update_unit (
    input  logic                clk,
    input  logic                reset,
    meta_update_unit_if.slave   bus
);
    typedef struct packed {
        logic [31:0] addr;
        logic        dir_global;
        logic        dir_local;
    } entry_t;

    entry_t      queue_q [4];
    logic [1:0]  head_q;
    logic [1:0]  tail_q;
    logic [2:0]  count_q;
    logic        update_valid_q;
    logic [31:0] update_addr_q;
    logic        prefer_global_q;
    logic        order_error_q;
    logic        overflow_q;

    logic        full;
    logic        empty;
    logic        do_pop;
    logic        do_push;
    entry_t      head_entry;

    assign full       = (count_q == 3'd4);
    assign empty      = (count_q == 3'd0);
    assign head_entry = queue_q[head_q];
    // Flush cancels both sides of the queue in the cycle it is asserted.
    assign do_pop     = bus.resolve_valid && !empty && !bus.flush;
    assign do_push    = bus.pred_valid && (!full || do_pop) && !bus.flush;

    // NOTE: storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            queue_q[tail_q] <= '{addr: bus.pred_addr,
                                 dir_global: bus.pred_global,
                                 dir_local: bus.pred_local};
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            update_valid_q  <= 1'b0;
            update_addr_q   <= '0;
            prefer_global_q <= 1'b0;
            order_error_q   <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            update_valid_q <= 1'b0;
            if (bus.flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (bus.pred_valid && full && !do_pop) begin
                    overflow_q <= 1'b1;
                end
                if (do_push) begin
                    tail_q <= tail_q + 2'd1;
                end
                if (do_pop) begin
                    head_q <= head_q + 2'd1;
                    if (head_entry.addr != bus.resolve_addr) begin
                        order_error_q <= 1'b1;
                    end else if (head_entry.dir_global != head_entry.dir_local) begin
                        update_valid_q  <= 1'b1;
                        update_addr_q   <= head_entry.addr;
                        prefer_global_q <= (head_entry.dir_global == bus.resolve_taken);
                    end
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 3'd1;
                    2'b01:   count_q <= count_q - 3'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef META_UPDATE_STATS_EN
    logic [15:0] global_cnt_q;
    logic [15:0] local_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            global_cnt_q <= '0;
            local_cnt_q  <= '0;
        end else if (update_valid_q) begin
            if (prefer_global_q) begin
                if (global_cnt_q != 16'hFFFF) global_cnt_q <= global_cnt_q + 16'd1;
            end else begin
                if (local_cnt_q != 16'hFFFF) local_cnt_q <= local_cnt_q + 16'd1;
            end
        end
    end

    assign bus.global_correct_cnt = global_cnt_q;
    assign bus.local_correct_cnt  = local_cnt_q;
`else
    assign bus.global_correct_cnt = 16'd0;
    assign bus.local_correct_cnt  = 16'd0;
`endif

    assign bus.meta_update_valid  = update_valid_q;
    assign bus.meta_update_addr   = update_addr_q;
    assign bus.meta_prefer_global = prefer_global_q;
    assign bus.full               = full;
    assign bus.empty              = empty;
    assign bus.count              = count_q;
    assign bus.order_error        = order_error_q;
    assign bus.overflow           = overflow_q;
endmodule

// File: tb/tb_meta_update_unit.sv
// Directed self-checking bench for meta_update_unit; expected values are hand-derived.
module tb_meta_update_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    meta_update_unit_if bus ();

    meta_update_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pred(input logic [31:0] addr, input logic g, input logic l);
        bus.pred_valid  = 1'b1;
        bus.pred_addr   = addr;
        bus.pred_global = g;
        bus.pred_local  = l;
    endtask

    task automatic set_res(input logic [31:0] addr, input logic taken);
        bus.resolve_valid = 1'b1;
        bus.resolve_addr  = addr;
        bus.resolve_taken = taken;
    endtask

    task automatic clear_in();
        bus.pred_valid    = 1'b0;
        bus.pred_addr     = '0;
        bus.pred_global   = 1'b0;
        bus.pred_local    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_addr  = '0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_g;
        logic [31:0] exp_l;
        n_checks = 0;
        n_errors = 0;
        clear_in();
        reset = 1'b1;
        tick();
        tick();

        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_valid", 32'(bus.meta_update_valid), 32'd0);
        check("rst_addr", bus.meta_update_addr, 32'd0);
        check("rst_prefer", 32'(bus.meta_prefer_global), 32'd0);
        check("rst_order_err", 32'(bus.order_error), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_gcnt", 32'(bus.global_correct_cnt), 32'd0);
        check("rst_lcnt", 32'(bus.local_correct_cnt), 32'd0);
        reset = 1'b0;

        // Disagreeing predictors, global right -> strobe preferring global.
        set_pred(32'h0040_0010, 1'b1, 1'b0);
        tick();
        clear_in();
        check("push1_count", 32'(bus.count), 32'd1);
        check("push1_empty", 32'(bus.empty), 32'd0);
        set_res(32'h0040_0010, 1'b1);
        tick();
        clear_in();
        check("g_win_valid", 32'(bus.meta_update_valid), 32'd1);
        check("g_win_addr", bus.meta_update_addr, 32'h0040_0010);
        check("g_win_prefer", 32'(bus.meta_prefer_global), 32'd1);
        check("g_win_count", 32'(bus.count), 32'd0);
        tick();
        check("g_win_drop", 32'(bus.meta_update_valid), 32'd0);
        check("g_win_hold", bus.meta_update_addr, 32'h0040_0010);

        // Agreeing predictors -> no strobe, outputs hold.
        set_pred(32'h0040_0020, 1'b1, 1'b1);
        tick();
        clear_in();
        check("agree_count1", 32'(bus.count), 32'd1);
        set_res(32'h0040_0020, 1'b0);
        tick();
        clear_in();
        check("agree_valid", 32'(bus.meta_update_valid), 32'd0);
        check("agree_count0", 32'(bus.count), 32'd0);
        check("agree_hold", bus.meta_update_addr, 32'h0040_0010);

        // Disagreeing predictors, local right -> prefer local.
        set_pred(32'h0040_0040, 1'b0, 1'b1);
        tick();
        clear_in();
        set_res(32'h0040_0040, 1'b1);
        tick();
        clear_in();
        check("l_win_valid", 32'(bus.meta_update_valid), 32'd1);
        check("l_win_addr", bus.meta_update_addr, 32'h0040_0040);
        check("l_win_prefer", 32'(bus.meta_prefer_global), 32'd0);

        // Five pushes: fifth dropped with overflow; then four back-to-back resolves.
        for (int i = 0; i < 5; i++) begin
            set_pred(32'h0040_0100 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            if (i == 3) begin
                check("fill_count4", 32'(bus.count), 32'd4);
                check("fill_full", 32'(bus.full), 32'd1);
                check("fill_no_ovf", 32'(bus.overflow), 32'd0);
            end
        end
        clear_in();
        check("ovf_count", 32'(bus.count), 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_res(32'h0040_0100 + 32'(4 * i), (i % 2) == 0);
            tick();
            check("b2b_valid", 32'(bus.meta_update_valid), 32'd1);
            check("b2b_addr", bus.meta_update_addr, 32'h0040_0100 + 32'(4 * i));
            check("b2b_prefer", 32'(bus.meta_prefer_global), ((i % 2) == 0) ? 32'd1 : 32'd0);
        end
        clear_in();
        tick();
        check("b2b_end_valid", 32'(bus.meta_update_valid), 32'd0);
        check("b2b_end_empty", 32'(bus.empty), 32'd1);

        // Resolve while empty (the dropped fifth address) is ignored.
        set_res(32'h0040_0110, 1'b1);
        tick();
        clear_in();
        check("empty_res_valid", 32'(bus.meta_update_valid), 32'd0);
        check("empty_res_oerr", 32'(bus.order_error), 32'd0);
        check("empty_res_count", 32'(bus.count), 32'd0);

        // Simultaneous push and pop keeps count steady.
        set_pred(32'h0040_0050, 1'b1, 1'b0);
        tick();
        set_pred(32'h0040_0054, 1'b0, 1'b1);
        set_res(32'h0040_0050, 1'b1);
        tick();
        clear_in();
        check("pp_count", 32'(bus.count), 32'd1);
        check("pp_valid", 32'(bus.meta_update_valid), 32'd1);
        check("pp_addr", bus.meta_update_addr, 32'h0040_0050);
        check("pp_prefer", 32'(bus.meta_prefer_global), 32'd1);
        set_res(32'h0040_0054, 1'b0);
        tick();
        clear_in();
        check("pp2_valid", 32'(bus.meta_update_valid), 32'd1);
        check("pp2_addr", bus.meta_update_addr, 32'h0040_0054);
        check("pp2_prefer", 32'(bus.meta_prefer_global), 32'd1);
        check("pp2_count", 32'(bus.count), 32'd0);

        // Address mismatch: order error, entry popped, no strobe.
        set_pred(32'h0040_0030, 1'b1, 1'b0);
        tick();
        clear_in();
        set_res(32'h0040_0034, 1'b1);
        tick();
        clear_in();
        check("oerr_flag", 32'(bus.order_error), 32'd1);
        check("oerr_empty", 32'(bus.empty), 32'd1);
        check("oerr_valid", 32'(bus.meta_update_valid), 32'd0);

        // Flush at count 3 overrides concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            set_pred(32'h0040_0060 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        clear_in();
        check("pre_flush_count", 32'(bus.count), 32'd3);
        set_pred(32'h0040_006C, 1'b1, 1'b0);
        set_res(32'h0040_0060, 1'b1);
        bus.flush = 1'b1;
        tick();
        clear_in();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);
        check("flush_valid", 32'(bus.meta_update_valid), 32'd0);
        tick();
        check("flush_valid2", 32'(bus.meta_update_valid), 32'd0);
        check("flush_count2", 32'(bus.count), 32'd0);

        // Strobes so far: global-preferred 5, local-preferred 3.
`ifdef META_UPDATE_STATS_EN
        exp_g = 32'd5;
        exp_l = 32'd3;
`else
        exp_g = 32'd0;
        exp_l = 32'd0;
`endif
        check("stats_global", 32'(bus.global_correct_cnt), exp_g);
        check("stats_local", 32'(bus.local_correct_cnt), exp_l);

        // Reset mid-operation suppresses the pending strobe and clears flags.
        set_pred(32'h0040_0070, 1'b1, 1'b0);
        tick();
        clear_in();
        set_res(32'h0040_0070, 1'b1);
        reset = 1'b1;
        tick();
        clear_in();
        reset = 1'b0;
        check("mid_rst_valid", 32'(bus.meta_update_valid), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_oerr", 32'(bus.order_error), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        check("mid_rst_addr", bus.meta_update_addr, 32'd0);
        check("mid_rst_gcnt", 32'(bus.global_correct_cnt), 32'd0);
        tick();
        check("mid_rst_valid2", 32'(bus.meta_update_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule
